serial_tx_bridge: RTL and testbench

Buffered UART transmitter that sits directly downstream of the processor's serial output port. It accepts bytes from the processor's `serial_out` / `serial_wren_out` pair, queues them in a small FIFO, and shifts them out on a single TX line as 8N1 frames. The FIFO's not-full status drives the processor's `serial_ready_in`, so firmware can poll for space before each store to the serial MMIO address.

---
 rtl/serial_tx_bridge_if.sv | 23 ++
 rtl/serial_tx_bridge.sv | 171 +++++++++++++++++
 tb/tb_serial_tx_bridge.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_tx_bridge_if.sv
// ============================================================================
// serial_tx_bridge_if
// ----------------------------------------------------------------------------
// Byte write port between the processor's serial MMIO output and the
// buffered UART transmitter.
//
// Signals:
//   wr_data : byte to enqueue (processor serial_out)
//   wr_en   : enqueue strobe, one byte per rising edge (serial_wren_out)
//   ready   : transmitter FIFO not full (processor serial_ready_in)
//
// Modports:
//   master : processor side, drives wr_data/wr_en, observes ready
//   slave  : transmitter side, observes wr_data/wr_en, drives ready
// ============================================================================
interface serial_tx_bridge_if;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       ready;

    modport master (output wr_data, output wr_en, input  ready);
    modport slave  (input  wr_data, input  wr_en, output ready);
endinterface

// File: rtl/serial_tx_bridge.sv
// ============================================================================
// serial_tx_bridge
// ----------------------------------------------------------------------------
// Buffered 8N1 UART transmitter. Bytes written by the processor are queued
// in a power-of-two circular FIFO and shifted out LSB first on txd.
//
// Parameters:
//   CLKS_PER_BIT : clock cycles per UART bit (>= 2)
//   FIFO_DEPTH   : FIFO entries (power of two, >= 2)
//
// Ports:
//   clock      : sole clock, rising edge
//   reset      : synchronous, active-high; clears FIFO, FSM and flags
//   wr_if      : write port (wr_data, wr_en in; ready out = FIFO not full)
//   txd        : registered UART line, idles high
//   busy       : FSM not idle or FIFO non-empty
//   overflow   : sticky, set when a write arrives while full
//   fifo_count : current FIFO occupancy
// ============================================================================
module serial_tx_bridge #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    serial_tx_bridge_if.slave           wr_if,
    output logic                        txd,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // FIFO storage and bookkeeping
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    // Transmit FSM
    logic [1:0]        r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_txd;

    logic w_ready;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_baud_done;

    // ready comes from the registered count only, so a pop in the same cycle
    // never rescues a write issued while full.
    assign w_ready     = (r_count != FULL_COUNT);
    assign w_empty     = (r_count == '0);
    assign w_push      = wr_if.wr_en && w_ready;
    assign w_pop       = (r_state == S_IDLE) && !w_empty;
    assign w_baud_done = (r_baud == BAUD_LAST);

    assign wr_if.ready = w_ready;
    assign txd         = r_txd;
    assign busy        = (r_state != S_IDLE) || !w_empty;
    assign overflow    = r_overflow;
    assign fifo_count  = r_count;

    // NOTE: storage has no reset; a byte is only read after the pointers say
    // it was written, so clearing the array would buy nothing.
    always_ff @(posedge clock) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= wr_if.wr_data;
        end
    end

    // NOTE: every sequential assignment is non-blocking so all registers
    // update from the same pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (wr_if.wr_en && !w_ready) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_txd <= 1'b1;
                    if (w_pop) begin
                        // Start bit is driven on the same edge as the pop.
                        r_shift <= r_mem[r_rd_ptr];
                        r_baud  <= '0;
                        r_txd   <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_done) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_txd     <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            // Next bit is the one about to land in shift[0].
                            r_shift   <= r_shift >> 1;
                            r_txd     <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_bridge.sv
// ============================================================================
// tb_serial_tx_bridge
// ----------------------------------------------------------------------------
// Directed bench for serial_tx_bridge with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change and outputs are sampled on the falling clock edge.
// ============================================================================
module tb_serial_tx_bridge;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clock;
    logic       reset;
    logic       txd;
    logic       busy;
    logic       overflow;
    logic [2:0] fifo_count;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    serial_tx_bridge_if bus ();

    serial_tx_bridge #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_if      (bus),
        .txd        (txd),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // Waits (bounded) for a start bit, then samples each bit mid-period.
    // Called on a falling edge; returns on the falling edge mid stop bit.
    task automatic recv_frame(output logic [7:0] data, output int start_cyc);
        int waited = 0;
        data      = 8'h00;
        start_cyc = 0;
        while (txd !== 1'b0 && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 200) begin
            check("frame_timeout", 32'd1, 32'd0);
            return;
        end
        start_cyc = cyc;
        repeat (2) @(negedge clock);
        check("start_bit", {31'd0, txd}, 32'd0);
        for (int b = 0; b < 8; b++) begin
            repeat (CPB) @(negedge clock);
            data[b] = txd;
        end
        repeat (CPB) @(negedge clock);
        check("stop_bit", {31'd0, txd}, 32'd1);
    endtask

    initial begin
        logic [7:0] got_byte;
        logic [9:0] line_seq;
        logic [3:0] level;
        int         t_prev;
        int         t_now;
        int         lows;

        reset       = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h77;

        // ---------------- reset state (wr_en ignored while in reset) -------
        repeat (2) @(negedge clock);
        bus.wr_en = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_txd",      {31'd0, txd},      32'd1);
        check("rst_ready",    {31'd0, bus.ready}, 32'd1);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_count",    {29'd0, fifo_count}, 32'd0);

        // ---------------- single byte 0x48 ----------------------------------
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h48;
        @(negedge clock);
        bus.wr_en = 1'b0;
        check("single_count", {29'd0, fifo_count}, 32'd1);
        check("single_txd_hi", {31'd0, txd}, 32'd1);
        check("single_busy", {31'd0, busy}, 32'd1);
        @(negedge clock);
        check("single_fall", {31'd0, txd}, 32'd0);
        line_seq = {1'b1, 8'h48, 1'b0};     // stop, data MSB..LSB, start
        for (int n = 0; n < 10; n++) begin
            for (int s = 0; s < CPB; s++) begin
                level[s] = txd;
                @(negedge clock);
            end
            check($sformatf("single_bit%0d", n), {28'd0, level}, {28'd0, {4{line_seq[n]}}});
        end
        check("single_busy_end", {31'd0, busy}, 32'd0);
        check("single_idle_txd", {31'd0, txd},  32'd1);

        // ---------------- fill and overflow ---------------------------------
        do_reset();
        fork
            begin
                logic [2:0] exp_cnt [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
                for (int i = 0; i < 6; i++) begin
                    bus.wr_en   = 1'b1;
                    bus.wr_data = 8'h41 + 8'(i);
                    @(negedge clock);
                    check($sformatf("fill_count%0d", i), {29'd0, fifo_count}, {29'd0, exp_cnt[i]});
                    if (i == 4) check("fill_ready_low", {31'd0, bus.ready}, 32'd0);
                end
                bus.wr_en = 1'b0;
                check("fill_overflow", {31'd0, overflow}, 32'd1);
            end
            begin
                t_prev = 0;
                for (int f = 0; f < 5; f++) begin
                    recv_frame(got_byte, t_now);
                    check($sformatf("fill_frame%0d", f), {24'd0, got_byte}, 32'h41 + 32'(f));
                    if (f > 0) check($sformatf("fill_gap%0d", f), 32'(t_now - t_prev), 32'd41);
                    t_prev = t_now;
                end
            end
        join
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (txd !== 1'b1) lows++;
        end
        check("fill_no_sixth", 32'(lows), 32'd0);
        check("fill_drained", {29'd0, fifo_count}, 32'd0);

        // ---------------- wrap-around streaming -----------------------------
        do_reset();
        fork
            begin
                int sent  = 0;
                int guard = 0;
                while (sent < 10 && guard < 2000) begin
                    if (bus.ready === 1'b1) begin
                        bus.wr_en   = 1'b1;
                        bus.wr_data = 8'(sent);
                        sent++;
                    end else begin
                        bus.wr_en = 1'b0;
                    end
                    @(negedge clock);
                    guard++;
                end
                bus.wr_en = 1'b0;
                check("wrap_all_sent", 32'(sent), 32'd10);
            end
            begin
                for (int f = 0; f < 10; f++) begin
                    recv_frame(got_byte, t_now);
                    check($sformatf("wrap_frame%0d", f), {24'd0, got_byte}, 32'(f));
                end
            end
        join
        check("wrap_overflow", {31'd0, overflow}, 32'd0);

        // ---------------- reset mid-frame -----------------------------------
        do_reset();
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hA5;
        @(negedge clock);
        bus.wr_data = 8'h5A;
        @(negedge clock);
        bus.wr_en = 1'b0;
        check("mid_start", {31'd0, txd}, 32'd0);
        repeat (17) @(negedge clock);
        check("mid_bit3", {31'd0, txd}, 32'd0);  // 0xA5 bit 3 = 0
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_txd",   {31'd0, txd}, 32'd1);
        check("mid_rst_count", {29'd0, fifo_count}, 32'd0);
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (txd !== 1'b1) lows++;
        end
        check("mid_no_frames", 32'(lows), 32'd0);
        check("mid_busy", {31'd0, busy}, 32'd0);

        // ---------------- step gating ---------------------------------------
        lows = 0;
        t_now = 0;
        bus.wr_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.wr_data = (i % 2 == 0) ? 8'hFF : 8'h00;
            @(negedge clock);
            if (fifo_count !== 3'd0) t_now++;
            if (txd !== 1'b1) lows++;
        end
        check("gate_count", 32'(t_now), 32'd0);
        check("gate_txd",   32'(lows),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
